// File: rtl/loader_mem_pkg.sv
// loader_mem_pkg: shared types and defaults for the loader/core memory arbiter
package loader_mem_pkg;
  localparam int ADDR_W_DEFAULT = 22;
  typedef enum logic [1:0] {IDLE, SERVE_LD, SERVE_CORE} state_t;
  typedef enum logic {SRC_CORE, SRC_LD} src_t;
endpackage

// File: rtl/ld_write_fifo.sv
// ld_write_fifo: synchronous loader write FIFO with registered occupancy count
module ld_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // full is judged on the registered count, so a same-edge pop never frees space
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/loader_mem_arbiter.sv
// loader_mem_arbiter: shares one memory port between a queued loader and a core
module loader_mem_arbiter import loader_mem_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_write,
  output logic              ld_pending,
  output logic              ld_overflow,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic              core_ack,
  output logic [7:0]        core_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  src_t last_grant;
  logic [ADDR_W+7:0] head;
  logic [CW-1:0] count;
  logic full, empty, pop, core_live, urgent, grant_ld, grant_core;
  ld_write_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + 8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(ld_write),
    .pop(pop),
    .din({ld_addr, ld_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign pop = state == SERVE_LD && mem_ack;
  // while core_ack is out the core still holds the request it just completed
  assign core_live = core_req && !core_ack;
  assign urgent = count >= CW'(FIFO_DEPTH - 1);
  assign grant_ld = !empty && (!core_live || urgent || last_grant == SRC_CORE);
  assign grant_core = core_live && !grant_ld;
  assign ld_pending = !empty || state == SERVE_LD;
  always_comb begin
    state_nx = state == IDLE ? (grant_ld ? SERVE_LD : grant_core ? SERVE_CORE : IDLE) :
               mem_ack ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_ack <= 1'b0;
      core_rdata <= '0;
      ld_overflow <= 1'b0;
      last_grant <= SRC_CORE;
    end else begin
      core_ack <= state == SERVE_CORE && mem_ack;
      if (ld_write && full) ld_overflow <= 1'b1;
      if (state == IDLE && (grant_ld || grant_core)) begin
        mem_req <= 1'b1;
        mem_we <= grant_ld || core_we;
        mem_addr <= grant_ld ? head[ADDR_W+7:8] : core_addr;
        mem_wdata <= grant_ld ? head[7:0] : core_wdata;
      end else if (state != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        last_grant <= state == SERVE_LD ? SRC_LD : SRC_CORE;
        if (state == SERVE_CORE) core_rdata <= mem_rdata;
      end
    end
  end
endmodule
